// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control: decodes in ID and carries control bundles through ID/EX, EX/MEM and MEM/WB.
// Includes load-use stall, branch flush and external hold.
module ctrl_pipe #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 4,
    parameter bit          CSR_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [6:0]          op_code,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                flush_ex,
    input  logic                hold_in,
    output logic                stall_if_id,
    output logic                id_illegal,
    output logic                ex_valid,
    output logic                ex_alu_src_b,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                mem_valid,
    output logic                mem_branch,
    output logic                mem_b_type,
    output logic                mem_write,
    output logic                mem_read,
    output logic [REG_AW-1:0]   mem_rd,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic [1:0]          wb_mem_to_reg,
    output logic [REG_AW-1:0]   wb_rd
);

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    logic       dec_legal;
    logic       dec_reg_write;
    logic       dec_alu_src_b;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_mem_to_reg;
    logic       dec_mem_write;
    logic       dec_mem_read;
    logic       dec_branch;
    logic       dec_b_type;
    logic       rs1_used;
    logic       rs2_used;

    always_comb begin
        dec_legal      = 1'b1;
        dec_reg_write  = 1'b0;
        dec_alu_src_b  = 1'b0;
        dec_alu_op     = '0;
        dec_mem_to_reg = '0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_branch     = 1'b0;
        dec_b_type     = 1'b0;
        rs1_used       = 1'b1;
        rs2_used       = 1'b0;
        case (op_code)
            OPC_OP_IMM: begin
                dec_reg_write = 1'b1;
                dec_alu_src_b = 1'b1;
                dec_alu_op    = {funct7_5 & (funct3 == 3'b101), funct3};
            end
            OPC_OP: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = {funct7_5, funct3};
                rs2_used      = 1'b1;
            end
            OPC_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src_b  = 1'b1;
                dec_mem_to_reg = 2'b11;
                dec_mem_read   = 1'b1;
            end
            OPC_STORE: begin
                dec_alu_src_b = 1'b1;
                dec_mem_write = 1'b1;
                rs2_used      = 1'b1;
            end
            OPC_BRANCH: begin
                dec_alu_op = 4'b1000;
                dec_branch = 1'b1;
                dec_b_type = (funct3 == 3'b000);
                rs2_used   = 1'b1;
            end
            OPC_LUI: begin
                dec_reg_write  = 1'b1;
                dec_alu_src_b  = 1'b1;
                dec_mem_to_reg = 2'b01;
                rs1_used       = 1'b0;
            end
            OPC_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_alu_src_b = 1'b1;
                rs1_used      = 1'b0;
            end
            OPC_JAL: begin
                dec_reg_write  = 1'b1;
                dec_mem_to_reg = 2'b10;
                rs1_used       = 1'b0;
            end
            OPC_JALR: begin
                dec_reg_write  = 1'b1;
                dec_alu_src_b  = 1'b1;
                dec_mem_to_reg = 2'b10;
            end
            OPC_SYSTEM: begin
                if (CSR_EN) begin
                    dec_reg_write = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                    rs1_used  = 1'b0;
                end
            end
            default: begin
                dec_legal = 1'b0;
                rs1_used  = 1'b0;
            end
        endcase
    end

    // Carried bundle bits held in ID/EX and EX/MEM that are not ports at that stage
    logic              ex_branch, ex_b_type, ex_mem_write, ex_mem_read, ex_reg_write;
    logic [1:0]        ex_mem_to_reg;
    logic              mem_reg_write;
    logic [1:0]        mem_mem_to_reg;

    logic lu;
    logic id_bubble;

    assign id_illegal = id_valid & ~dec_legal;

    assign lu = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                ((rs1_used & (id_rs1 == ex_rd)) | (rs2_used & (id_rs2 == ex_rd)));

    assign stall_if_id = hold_in | (~flush_ex & lu);
    assign id_bubble   = flush_ex | lu | ~id_valid | ~dec_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_alu_src_b   <= 1'b0;
            ex_alu_op      <= '0;
            ex_rd          <= '0;
            ex_branch      <= 1'b0;
            ex_b_type      <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= '0;
            mem_valid      <= 1'b0;
            mem_branch     <= 1'b0;
            mem_b_type     <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= '0;
            wb_rd          <= '0;
        end else if (!hold_in) begin
            if (id_bubble) begin
                ex_valid      <= 1'b0;
                ex_alu_src_b  <= 1'b0;
                ex_alu_op     <= '0;
                ex_rd         <= '0;
                ex_branch     <= 1'b0;
                ex_b_type     <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_to_reg <= '0;
            end else begin
                ex_valid      <= 1'b1;
                ex_alu_src_b  <= dec_alu_src_b;
                ex_alu_op     <= ALU_OP_W'(dec_alu_op);
                ex_rd         <= id_rd;
                ex_branch     <= dec_branch;
                ex_b_type     <= dec_b_type;
                ex_mem_write  <= dec_mem_write;
                ex_mem_read   <= dec_mem_read;
                // rd=0 writes are dropped at decode; rd itself is still carried
                ex_reg_write  <= dec_reg_write & (id_rd != '0);
                ex_mem_to_reg <= dec_mem_to_reg;
            end
            mem_valid      <= ex_valid;
            mem_branch     <= ex_branch;
            mem_b_type     <= ex_b_type;
            mem_write      <= ex_mem_write;
            mem_read       <= ex_mem_read;
            mem_rd         <= ex_rd;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            wb_valid       <= mem_valid;
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_rd          <= mem_rd;
        end
    end

endmodule
